// File: rtl/lsu_bus_if_pkg.sv
// Shared types and access-size encodings for the load/store bus interface.
package lsu_bus_if_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // H/HU need a[0] = 0; W and the reserved encodings need a[1:0] = 00.
  function automatic logic ls_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic [2:0] sz;
    sz = f3 & 3'b011;
    if (sz == LS_B) return 1'b0;
    if (sz == LS_H) return off[0];
    return (sz == LS_W || sz == 3'b011) ? (off != 2'b00) : 1'b0;
  endfunction

endpackage

// File: rtl/lsu_bus_if_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction/extension.
module lsu_bus_if_align
  import lsu_bus_if_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  always_comb begin
    o_be      = 4'b1111;
    o_st_data = i_st_data;
    case (i_st_funct3 & 3'b011)
      LS_B: begin
        o_be      = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      LS_H: begin
        o_be      = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte     = i_ld_data[{i_ld_off, 3'b000} +: 8];
  assign w_half     = i_ld_off[1] ? i_ld_data[31:16] : i_ld_data[15:0];
  assign w_unsigned = (i_ld_funct3 == LS_BU) || (i_ld_funct3 == LS_HU);

  always_comb begin
    o_ld_data = i_ld_data;
    case (i_ld_funct3 & 3'b011)
      LS_B:    o_ld_data = {{24{~w_unsigned & w_byte[7]}}, w_byte};
      LS_H:    o_ld_data = {{16{~w_unsigned & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit bus interface: one access per request on a req/gnt/rvalid bus.
// Optional macro LSU_MISALIGN_TRAP_EN adds o_misaligned and skips the bus for misaligned accesses.
module lsu_bus_if
  import lsu_bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bus_req,
  input  logic              i_bus_gnt,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_rvalid,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              o_misaligned,
`endif
  input  logic [DATA_W-1:0] i_bus_rdata
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("lsu_bus_if: DATA_W must be 32");
  end

  lsu_state_e        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_bus_req;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              r_misaligned;
`endif

  logic              w_req;
  logic              w_stall;
  logic [3:0]        w_be;
  logic [31:0]       w_st_data;
  logic [31:0]       w_ld_data;

  assign w_req = i_mem_read | i_mem_write;

  lsu_bus_if_align u_align (
    .i_st_funct3 (i_funct3),
    .i_st_off    (i_addr[1:0]),
    .i_st_data   (i_wdata),
    .o_be        (w_be),
    .o_st_data   (w_st_data),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_ld_data   (i_bus_rdata),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_bus_addr   <= '0;
      r_bus_be     <= 4'b0000;
      r_bus_wdata  <= '0;
      r_bus_req    <= 1'b0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_done       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (ls_misaligned(i_funct3, i_addr[1:0])) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
`else
            begin
`endif
              // A simultaneous read and write resolves to the store.
              r_we        <= i_mem_write;
              r_funct3    <= i_funct3;
              r_off       <= i_addr[1:0];
              r_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_st_data;
              r_bus_req   <= 1'b1;
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          if (i_bus_gnt) begin
            r_bus_req <= 1'b0;
            if (r_we) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_bus_rvalid) begin
            r_rdata <= w_ld_data;
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:      w_stall = w_req;
      REQ, WAIT: w_stall = 1'b1;
      default:   w_stall = 1'b0;
    endcase
  end

  // Gate with reset so the combinational stall is also 0 while reset is held.
  assign o_stall     = w_stall & i_rst_n;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if: expected bus fields/results queued at issue, checked at done.
module tb_lsu_bus_if;
  import lsu_bus_if_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_bus_req;
  logic        i_bus_gnt = 1'b0;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  lsu_bus_if dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_stall      (o_stall),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_bus_req    (o_bus_req),
    .i_bus_gnt    (i_bus_gnt),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_rvalid (i_bus_rvalid),
`ifdef LSU_MISALIGN_TRAP_EN
    .o_misaligned (o_misaligned),
`endif
    .i_bus_rdata  (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_stall"}, 32'(o_stall), 32'd0);
    check_eq({tag, "_done"}, 32'(o_done), 32'd0);
    check_eq({tag, "_rdata"}, o_rdata, 32'd0);
    check_eq({tag, "_req"}, 32'(o_bus_req), 32'd0);
    check_eq({tag, "_we"}, 32'(o_bus_we), 32'd0);
    check_eq({tag, "_addr"}, o_bus_addr, 32'd0);
    check_eq({tag, "_be"}, 32'(o_bus_be), 32'd0);
    check_eq({tag, "_wdata"}, o_bus_wdata, 32'd0);
  endtask

  // Issue one access, act as bus slave with the given grant/rvalid delays, check at done.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] bus_rdata, input int gdly, input int rdly,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata, input int e_lat);
    exp_t e;
    int   cyc = 1;
    int   nreq = 0;
    int   nwait = 0;
    bit   granted = 1'b0;
    bit   finished = 1'b0;
    e = '{addr: e_addr, be: e_be, wdata: e_wdata, we: wr, rdata: e_rdata, lat: e_lat};
    sb_q.push_back(e);
    @(negedge i_clk);
    i_mem_read  = rd;
    i_mem_write = wr;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wdata;
    #1 check_eq({tag, "_stall_idle"}, 32'(o_stall), 32'd1);
    while (!finished) begin
      @(negedge i_clk);
      cyc++;
      i_bus_gnt    = 1'b0;
      i_bus_rvalid = 1'b0;
      if (o_done) begin
        finished = 1'b1;
      end else if (cyc > 40) begin
        check_eq({tag, "_timeout_cycles"}, 32'(cyc), 32'(e_lat));
        finished = 1'b1;
      end else if (o_bus_req) begin
        if (nreq == 0 || nreq == gdly) begin
          check_eq({tag, "_bus_addr"}, o_bus_addr, sb_q[0].addr);
          check_eq({tag, "_bus_be"}, 32'(o_bus_be), 32'(sb_q[0].be));
          check_eq({tag, "_bus_we"}, 32'(o_bus_we), 32'(sb_q[0].we));
          if (sb_q[0].we) check_eq({tag, "_bus_wdata"}, o_bus_wdata, sb_q[0].wdata);
          check_eq({tag, "_stall_req"}, 32'(o_stall), 32'd1);
        end
        if (nreq == gdly) begin
          i_bus_gnt = 1'b1;
          granted   = 1'b1;
        end
        nreq++;
      end else if (granted) begin
        check_eq({tag, "_stall_wait"}, 32'(o_stall), 32'd1);
        if (nwait == rdly) begin
          i_bus_rvalid = 1'b1;
          i_bus_rdata  = bus_rdata;
        end
        nwait++;
      end
    end
    e = sb_q.pop_front();
    check_eq({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check_eq({tag, "_rdata"}, o_rdata, e.rdata);
    check_eq({tag, "_stall_done"}, 32'(o_stall), 32'd0);
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    @(negedge i_clk);
    check_eq({tag, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int done_seen;
    #1 check_outputs_zero("reset");
    @(negedge i_clk);
    check_outputs_zero("reset_hold");
    i_rst_n = 1'b1;

    run_op("sb", 0, 1, LS_B, 32'h1003, 32'h0000_00AB, 32'h0, 0, 0,
           32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 3);
    run_op("lb", 1, 0, LS_B, 32'h2001, 32'h0, 32'h0000_F000, 0, 0,
           32'h2000, 4'b0010, 32'h0, 32'hFFFF_FFF0, 4);
    run_op("lbu", 1, 0, LS_BU, 32'h2001, 32'h0, 32'h0000_F000, 0, 0,
           32'h2000, 4'b0010, 32'h0, 32'h0000_00F0, 4);
    run_op("lh", 1, 0, LS_H, 32'h2002, 32'h0, 32'h8001_1234, 0, 0,
           32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 4);
    run_op("lhu", 1, 0, LS_HU, 32'h2002, 32'h0, 32'h8001_1234, 0, 0,
           32'h2000, 4'b1100, 32'h0, 32'h0000_8001, 4);
    run_op("sh", 0, 1, LS_H, 32'h0106, 32'h5555_BEEF, 32'h0, 0, 0,
           32'h0104, 4'b1100, 32'hBEEF_BEEF, 32'h0000_8001, 3);
    run_op("lw_slow", 1, 0, LS_W, 32'h3004, 32'h0, 32'hDEAD_BEEF, 3, 2,
           32'h3004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 9);
    run_op("rw_both", 1, 1, LS_W, 32'h0200, 32'hCAFE_F00D, 32'h1111_1111, 1, 0,
           32'h0200, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4);
    run_op("lw_rsvd", 1, 0, 3'b011, 32'h0010, 32'h0, 32'h8765_4321, 0, 1,
           32'h0010, 4'b1111, 32'h0, 32'h8765_4321, 5);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge i_clk);
    i_mem_read = 1'b1;
    i_funct3   = LS_W;
    i_addr     = 32'h0006;
    #1 check_eq("mis_stall_idle", 32'(o_stall), 32'd1);
    @(negedge i_clk);
    check_eq("mis_done", 32'(o_done), 32'd1);
    check_eq("mis_flag", 32'(o_misaligned), 32'd1);
    check_eq("mis_no_req", 32'(o_bus_req), 32'd0);
    check_eq("mis_rdata", o_rdata, 32'h8765_4321);
    check_eq("mis_stall_done", 32'(o_stall), 32'd0);
    i_mem_read = 1'b0;
    @(negedge i_clk);
    check_eq("mis_done_pulse", 32'(o_done), 32'd0);
    check_eq("mis_flag_pulse", 32'(o_misaligned), 32'd0);
`else
    run_op("lh_trunc", 1, 0, LS_H, 32'h2003, 32'h0, 32'h8001_1234, 0, 0,
           32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 4);
    run_op("lw_trunc", 1, 0, LS_W, 32'h2006, 32'h0, 32'h1122_3344, 0, 0,
           32'h2004, 4'b1111, 32'h0, 32'h1122_3344, 4);
`endif

    // Reset while waiting for read data; late rvalid must be ignored.
    @(negedge i_clk);
    i_mem_read = 1'b1;
    i_funct3   = LS_W;
    i_addr     = 32'h0080;
    @(negedge i_clk);
    check_eq("rst_req", 32'(o_bus_req), 32'd1);
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt = 1'b0;
    check_eq("rst_wait_req_low", 32'(o_bus_req), 32'd0);
    check_eq("rst_wait_stall", 32'(o_stall), 32'd1);
    i_rst_n    = 1'b0;
    i_mem_read = 1'b0;
    #1 check_outputs_zero("rst_mid");
    @(negedge i_clk);
    i_bus_rvalid = 1'b1;
    i_bus_rdata  = 32'hBAD0_BAD0;
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_bus_rvalid = 1'b0;
      done_seen |= 32'(o_done);
    end
    check_eq("rst_no_done", 32'(done_seen), 32'd0);
    check_eq("rst_rdata_cleared", o_rdata, 32'd0);

    run_op("sw_after_rst", 0, 1, LS_W, 32'h0040, 32'h1234_5678, 32'h0, 0, 0,
           32'h0040, 4'b1111, 32'h1234_5678, 32'h0, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
